// File: rtl/bcd_digit_packer.sv
// rtl/bcd_digit_packer.sv - collects two BCD digits MSD-first and presents a range-checked packed BCD word
module bcd_digit_packer #(
    parameter int MAX_VALUE = 63,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           digit_in,
    input  logic                 digit_valid,
    output logic                 digit_ready,
    input  logic                 enter,
    input  logic                 clear,
    output logic [7:0]           bcd_out,
    output logic                 bcd_valid,
    input  logic                 bcd_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        HAVE_ONE = 2'd1,
        OUT      = 2'd2
    } state_t;

    localparam logic [6:0] MAX_V = 7'(MAX_VALUE);

    state_t     state, state_n;
    logic [3:0] tens, tens_n;
    logic [7:0] bcd_out_n;
    logic       err_n;
    logic       accept;
    logic       digit_ok;
    logic [6:0] value;

    assign digit_ready = (state != OUT);
    assign bcd_valid   = (state == OUT);
    assign accept      = digit_valid && digit_ready;
    assign digit_ok    = (digit_in <= 4'd9);
    assign value       = 7'(tens) * 7'd10 + 7'(digit_in);

    always_comb begin
        state_n   = state;
        tens_n    = tens;
        bcd_out_n = bcd_out;
        err_n     = 1'b0;
        if (clear) begin
            state_n = EMPTY;
            tens_n  = 4'h0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        if (!digit_ok) begin
                            err_n = 1'b1;
                        end else begin
                            tens_n  = digit_in;
                            state_n = HAVE_ONE;
                        end
                    end
                end
                HAVE_ONE: begin
                    // An accepted digit, even a rejected one, takes precedence over enter.
                    if (accept) begin
                        if (!digit_ok) begin
                            err_n = 1'b1;
                        end else if (value <= MAX_V) begin
                            bcd_out_n = {tens, digit_in};
                            state_n   = OUT;
                        end else begin
                            err_n   = 1'b1;
                            tens_n  = 4'h0;
                            state_n = EMPTY;
                        end
                    end else if (enter) begin
                        if (7'(tens) <= MAX_V) begin
                            bcd_out_n = {4'h0, tens};
                            state_n   = OUT;
                        end else begin
                            err_n   = 1'b1;
                            tens_n  = 4'h0;
                            state_n = EMPTY;
                        end
                    end
                end
                OUT: begin
                    if (bcd_ready) begin
                        tens_n  = 4'h0;
                        state_n = EMPTY;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    tens_n  = 4'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            tens      <= 4'h0;
            bcd_out   <= 8'h00;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state   <= state_n;
            tens    <= tens_n;
            bcd_out <= bcd_out_n;
            err     <= err_n;
            if (err_n && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_packer.sv
// tb/tb_bcd_digit_packer.sv - directed self-checking bench for bcd_digit_packer
module tb_bcd_digit_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       enter;
    logic       clear;
    logic [7:0] bcd_out;
    logic       bcd_valid;
    logic       bcd_ready;
    logic       err;
    logic [7:0] err_count;

    int tests_run = 0;
    int tests_failed = 0;

    bcd_digit_packer #(.MAX_VALUE(63), .ERR_CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .enter       (enter),
        .clear       (clear),
        .bcd_out     (bcd_out),
        .bcd_valid   (bcd_valid),
        .bcd_ready   (bcd_ready),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    initial begin
        rst = 1'b1; digit_in = 4'h0; digit_valid = 1'b0;
        enter = 1'b0; clear = 1'b0; bcd_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", bcd_valid, 0);
        check("rst_out", bcd_out, 8'h00);
        check("rst_err", err, 0);
        check("rst_cnt", err_count, 0);
        check("rst_ready", digit_ready, 1);

        // 2,3 -> 0x23 for exactly one cycle
        send_digit(4'd2);
        check("23_first_valid", bcd_valid, 0);
        check("23_first_ready", digit_ready, 1);
        send_digit(4'd3);
        check("23_valid", bcd_valid, 1);
        check("23_out", bcd_out, 8'h23);
        check("23_ready_low", digit_ready, 0);
        tick();
        check("23_drop", bcd_valid, 0);
        check("23_empty_ready", digit_ready, 1);

        // 64 exceeds the range
        send_digit(4'd6);
        send_digit(4'd4);
        check("64_err", err, 1);
        check("64_cnt", err_count, 1);
        check("64_valid", bcd_valid, 0);
        tick();
        check("64_err_pulse", err, 0);
        send_digit(4'd6);
        send_digit(4'd3);
        check("63_valid", bcd_valid, 1);
        check("63_out", bcd_out, 8'h63);
        check("63_err", err, 0);
        tick();

        // single digit commit and enter while empty
        send_digit(4'd7);
        pulse_enter();
        check("07_valid", bcd_valid, 1);
        check("07_out", bcd_out, 8'h07);
        tick();
        pulse_enter();
        check("enter_empty_valid", bcd_valid, 0);
        check("enter_empty_err", err, 0);
        check("enter_empty_cnt", err_count, 1);

        // backpressure hold
        bcd_ready = 1'b0;
        send_digit(4'd5);
        send_digit(4'd8);
        for (int i = 0; i < 4; i++) begin
            check("58_hold_valid", bcd_valid, 1);
            check("58_hold_out", bcd_out, 8'h58);
            check("58_hold_ready", digit_ready, 0);
            digit_in = 4'd1; digit_valid = 1'b1;
            tick();
            digit_valid = 1'b0;
        end
        bcd_ready = 1'b1;
        tick();
        check("58_drop", bcd_valid, 0);
        check("58_after_ready", digit_ready, 1);
        send_digit(4'd1);
        send_digit(4'd2);
        check("12_out", bcd_out, 8'h12);
        check("12_valid", bcd_valid, 1);
        tick();

        // invalid digit, then clear with a digit
        send_digit(4'hC);
        check("C_err", err, 1);
        check("C_cnt", err_count, 2);
        check("C_valid", bcd_valid, 0);
        send_digit(4'd1);
        clear = 1'b1;
        send_digit(4'd0);
        clear = 1'b0;
        check("clr_valid", bcd_valid, 0);
        check("clr_err", err, 0);
        send_digit(4'd1);
        check("clr_next_valid", bcd_valid, 0);
        send_digit(4'd0);
        check("10_valid", bcd_valid, 1);
        check("10_out", bcd_out, 8'h10);
        tick();

        // clear drops a pending output even with bcd_ready high
        bcd_ready = 1'b0;
        send_digit(4'd4);
        send_digit(4'd2);
        check("42_valid", bcd_valid, 1);
        clear = 1'b1; bcd_ready = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_out_valid", bcd_valid, 0);
        check("clr_out_cnt", err_count, 2);
        send_digit(4'd3);
        check("3_single_valid", bcd_valid, 0);
        pulse_enter();
        check("03_out", bcd_out, 8'h03);
        check("03_valid", bcd_valid, 1);
        tick();

        // saturation
        digit_in = 4'hF; digit_valid = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        digit_valid = 1'b0;
        check("sat_cnt", err_count, 8'hFF);
        check("sat_err", err, 1);
        tick();
        check("sat_err_end", err, 0);
        check("sat_hold", err_count, 8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_cnt", err_count, 0);
        check("rst2_valid", bcd_valid, 0);
        check("rst2_ready", digit_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
